// File: rtl/rf_wb_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   WB_NREQ  : default number of writeback requesters (0 = pipeline WB stage)
//   WB_AW    : default register address width
//   WB_DW    : default write data width
//   RF_BYTES : byte-enable mask width (one bit per data byte)
//   wb_req_t : one requester's write payload {waddr, wbytes, wdata}
package rf_wb_pkg;

  localparam int WB_NREQ  = 3;
  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int RF_BYTES = WB_DW / 8;

  typedef struct packed {
    logic [WB_AW-1:0]    waddr;
    logic [RF_BYTES-1:0] wbytes;
    logic [WB_DW-1:0]    wdata;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin grant.
//   req     : request vector, one bit per requester
//   last    : index of the most recent grant; search starts at last+1
//   gnt     : one-hot grant (all-zero when nothing requests)
//   gnt_idx : binary index of the granted requester (0 when nothing requests)
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int   w_idx;
  logic w_found;

  // Walk last+1, last+2, ... last+N (wrapping), so the previous winner is
  // considered last and every requester is reached within N grants.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(last) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port between the pipeline WB
// stage (requester 0), the divider and the load-return path.
//   clk, reset               : clock; synchronous active-high reset
//   req_valid / req_ready    : per-requester handshake
//   req_waddr/wbytes/wdata   : per-requester payload, packed by index
//   rf_wen/waddr/wbytes/wdata: registered write into the regfile
//   grant_id                 : requester that produced the current rf_* write
//
// Handshake: a requester raises req_valid with a stable payload and holds it
// until it sees req_ready high in the same cycle; that cycle is the accept.
// req_ready is one-hot or zero, combinational from req_valid and the
// round-robin pointer only (the regfile never stalls), and is forced to zero
// while reset is high so nothing is consumed during reset.
module rf_wport_arbiter
  import rf_wb_pkg::*;
#(
  parameter int NREQ = WB_NREQ,
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*AW-1:0]       req_waddr,
  input  logic [NREQ*RF_BYTES-1:0] req_wbytes,
  input  logic [NREQ*DW-1:0]       req_wdata,
  output logic                     rf_wen,
  output logic [AW-1:0]            rf_waddr,
  output logic [RF_BYTES-1:0]      rf_wbytes,
  output logic [DW-1:0]            rf_wdata,
  output logic [IW-1:0]            grant_id
);

  logic [NREQ-1:0]     w_req_gated;
  logic [NREQ-1:0]     w_gnt;
  logic [IW-1:0]       w_gnt_idx;
  wb_req_t             w_req [NREQ];
  wb_req_t             w_sel;
  logic                w_accept;
  logic                w_write;

  logic [IW-1:0]       r_last;
  logic                r_wen;
  logic [AW-1:0]       r_waddr;
  logic [RF_BYTES-1:0] r_wbytes;
  logic [DW-1:0]       r_wdata;
  logic [IW-1:0]       r_grant_id;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_req[g] = {req_waddr[g*AW +: AW],
                       req_wbytes[g*RF_BYTES +: RF_BYTES],
                       req_wdata[g*DW +: DW]};
  end

  // Masking the requests (rather than the grant) keeps the pointer from
  // moving on a cycle whose accept is being discarded by reset.
  assign w_req_gated = reset ? '0 : req_valid;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr (
    .req     (w_req_gated),
    .last    (r_last),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;
  assign w_sel     = w_req[w_gnt_idx];

  // Writes to r0 or with an empty byte mask are consumed but never reach
  // the regfile.
  assign w_write = w_accept && (w_sel.waddr != '0) && (w_sel.wbytes != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last     <= IW'(NREQ - 1);
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wbytes   <= '0;
      r_wdata    <= '0;
      r_grant_id <= '0;
    end else begin
      r_wen <= w_write;
      if (w_accept) begin
        r_last     <= w_gnt_idx;
        r_grant_id <= w_gnt_idx;
      end
      // Payload only moves with a real write, so the last written address
      // and data remain visible across idle and dropped cycles.
      if (w_write) begin
        r_waddr  <= w_sel.waddr;
        r_wbytes <= w_sel.wbytes;
        r_wdata  <= w_sel.wdata;
      end
    end
  end

  assign rf_wen    = r_wen;
  assign rf_waddr  = r_waddr;
  assign rf_wbytes = r_wbytes;
  assign rf_wdata  = r_wdata;
  assign grant_id  = r_grant_id;

endmodule
